exe_unit: RTL and testbench
===========================

EXE_UNIT -- requirements
Module: exe_unit

Interface
REQ-001 Parameter: WIDTH, 32, datapath width for operands, result and addresses.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  upstream has a decoded instruction.
REQ-005 in_ready  out  1  unit can accept this cycle; transfer when in_valid && in_ready at a rising edge.
REQ-006 EXE_CMD  in  4  operation: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL/SLA, 1001 SRA, 1010 SRL.
REQ-007 br_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
REQ-008 val1, val2, src2_val  in  WIDTH each  ALU operand A, operand B (register or immediate), BNE compare value.
REQ-009 pc, br_offset  in  WIDTH each  instruction PC and branch offset.
REQ-010 out_valid  out  1  result registers hold a valid result.
REQ-011 out_ready  in  1  downstream consumes the result; transfer when out_valid && out_ready at a rising edge.
REQ-012 alu_result, br_addr  out  WIDTH each  ALU result; branch target pc + br_offset, modulo 2^WIDTH.
REQ-013 br_taken  out  1  branch/jump taken.

Function
REQ-014 States: IDLE, BUSY, DONE; out_valid SHALL be 1 exactly in DONE.
REQ-015 in_ready SHALL be 1 in IDLE, or in DONE while out_ready is 1; 0 in BUSY.
REQ-016 Non-shift commands, or shifts with val2[4:0]==0, on accept: result, br_taken, br_addr registered; state -> DONE (out_valid in cycle after accept).
REQ-017 Shift commands with k=val2[4:0]>0, on accept: acc<=val1, cnt<=k, state -> BUSY.
REQ-018 BUSY: one 1-bit shift of acc and cnt decrement per cycle; after the k-th shift state -> DONE, so out_valid is asserted k+1 cycles after accept.
REQ-019 SLL/SLA fill 0 from LSB; SRL fills 0 from MSB; SRA replicates acc[WIDTH-1].
REQ-020 ADD/SUB wrap modulo 2^WIDTH with no overflow flag; NOR = ~(val1|val2).
REQ-021 Undefined EXE_CMD SHALL produce alu_result 0 with 1-cycle latency.
REQ-022 br_taken: BEZ when val1==0; BNE when val1!=src2_val; JMP always; none 0. br_taken and br_addr are computed at accept and held through DONE.
REQ-023 DONE with out_ready 0: all outputs held stable.
REQ-024 DONE with out_ready 1 and in_valid 1: result released and the new instruction accepted in the same edge (back-to-back, no bubble).
REQ-025 DONE with out_ready 1 and in_valid 0: state -> IDLE; out_valid 0 the next cycle.
REQ-026 Inputs are ignored while in_ready is 0; operands are captured only at accept.

Reset
REQ-027 rst low SHALL immediately force IDLE, out_valid 0, alu_result 0, br_addr 0, br_taken 0, cnt 0, acc 0, regardless of state.
REQ-028 A BUSY shift interrupted by reset SHALL be discarded; no partial result SHALL be presented after reset release.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-030 EXE_CMD encodings, br_type encodings and state encodings SHALL live in shared package mips_defs, used by the decoder and this unit.
REQ-031 The iterative shifter (acc, cnt, direction and fill) SHALL be sub-module exe_shifter; ALU ops, branch logic and the FSM stay in exe_unit.

Verification
REQ-032 ADD: val1=7, val2=5, br_type=00, out_ready=1 -> out_valid in the next cycle, alu_result=12, br_taken=0.
REQ-033 SRA: val1=0x80000000, val2=4 -> in_ready 0 for 4 cycles, out_valid 5 cycles after accept, alu_result=0xF8000000.
REQ-034 BNE: val1=3, src2_val=4, pc=0x100, br_offset=0x20 -> br_taken=1, br_addr=0x120. BEZ with val1=1 -> br_taken=0.
REQ-035 Backpressure: out_ready=0 for 3 cycles after a SUB 2-5 -> alu_result=0xFFFFFFFD held stable, in_ready=0. Then out_ready=1 with a queued XOR -> accepted on the same edge.
REQ-036 Reset mid-shift: SLL val1=1, val2=20, rst low in cycle 3 -> outputs 0, IDLE. After release, ADD 1+1 -> alu_result=2 with no stale result.
REQ-037 Shift by 0 and undefined EXE_CMD=1111 -> 1-cycle latency, results val1 and 0 respectively.

Source files
------------

// File: rtl/mips_defs.sv
// mips_defs: encodings shared by the decoder and the execute unit.
//   exe_cmd_e   : ALU / shifter operation select (EXE_CMD)
//   br_type_e   : branch kind (br_type)
//   state_e     : execute-unit handshake FSM states
//   shift_dir_e : direction / fill mode of the iterative shifter
package mips_defs;

    // Shift amount field width taken from val2.
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        CMD_ADD = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_AND = 4'b0100,
        CMD_OR  = 4'b0101,
        CMD_NOR = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SLL = 4'b1000,  // also SLA
        CMD_SRA = 4'b1001,
        CMD_SRL = 4'b1010
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SH_LEFT        = 2'b00,
        SH_RIGHT_LOGIC = 2'b01,
        SH_RIGHT_ARITH = 2'b10
    } shift_dir_e;

    function automatic logic is_shift(input logic [3:0] cmd);
        return cmd inside {CMD_SLL, CMD_SRA, CMD_SRL};
    endfunction

    function automatic shift_dir_e shift_dir(input logic [3:0] cmd);
        case (cmd)
            CMD_SRA: return SH_RIGHT_ARITH;
            CMD_SRL: return SH_RIGHT_LOGIC;
            default: return SH_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/exe_unit_if.sv
// exe_unit_if: instruction-in / result-out handshake bundle of the execute unit.
//   master : upstream decoder + downstream consumer (drives instruction, out_ready)
//   slave  : exe_unit (drives in_ready, out_valid and the result fields)
interface exe_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       EXE_CMD;
    logic [1:0]       br_type;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] src2_val;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] br_offset;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] br_addr;
    logic             br_taken;

    modport master (
        output in_valid, EXE_CMD, br_type, val1, val2, src2_val, pc, br_offset, out_ready,
        input  in_ready, out_valid, alu_result, br_addr, br_taken
    );

    modport slave (
        input  in_valid, EXE_CMD, br_type, val1, val2, src2_val, pc, br_offset, out_ready,
        output in_ready, out_valid, alu_result, br_addr, br_taken
    );
endinterface

// File: rtl/exe_shifter.sv
// exe_shifter: one-bit-per-cycle shifter used for non-zero shift amounts.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : capture load_val / load_cnt / dir as a new shift job
//   step       : perform one 1-bit shift and decrement the count
//   shift_val  : acc shifted by one more bit (value after the next step)
//   last       : the next step is the final one
module exe_shifter
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  shift_dir_e         dir,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [SHAMT_W-1:0] load_cnt,
    output logic [WIDTH-1:0]   shift_val,
    output logic               last
);

    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    shift_dir_e         dir_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        shift_val = acc;
        case (dir_q)
            SH_LEFT:        shift_val = {acc[WIDTH-2:0], 1'b0};
            SH_RIGHT_LOGIC: shift_val = {1'b0, acc[WIDTH-1:1]};
            SH_RIGHT_ARITH: shift_val = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default:        shift_val = acc;
        endcase
    end

    assign last = (cnt == SHAMT_W'(1));

    // NOTE: acc and cnt are reset explicitly so a shift cut short by reset leaves no residue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            cnt   <= '0;
            dir_q <= SH_LEFT;
        end else if (load) begin
            acc   <= load_val;
            cnt   <= load_cnt;
            dir_q <= dir;
        end else if (step && cnt != '0) begin
            acc <= shift_val;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/exe_unit.sv
// exe_unit: execute stage -- ALU, branch resolution and iterative shifts behind
// a valid/ready handshake on both sides.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : exe_unit_if slave port (instruction in, result out)
module exe_unit
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    exe_unit_if.slave bus
);

    state_e             state, state_next;
    logic               accept;
    logic               long_shift;
    logic [SHAMT_W-1:0] shamt;
    logic               shift_step;
    logic               shift_last;
    logic [WIDTH-1:0]   shift_val;
    logic [WIDTH-1:0]   alu_comb;
    logic               taken_comb;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   addr_q;
    logic               taken_q;

    assign shamt      = bus.val2[SHAMT_W-1:0];
    assign long_shift = is_shift(bus.EXE_CMD) && (shamt != '0);
    assign accept     = bus.in_valid && bus.in_ready;

    // Single-cycle operations; shifts only land here with a zero amount.
    always_comb begin
        alu_comb = '0;
        case (bus.EXE_CMD)
            CMD_ADD: alu_comb = bus.val1 + bus.val2;
            CMD_SUB: alu_comb = bus.val1 - bus.val2;
            CMD_AND: alu_comb = bus.val1 & bus.val2;
            CMD_OR:  alu_comb = bus.val1 | bus.val2;
            CMD_NOR: alu_comb = ~(bus.val1 | bus.val2);
            CMD_XOR: alu_comb = bus.val1 ^ bus.val2;
            CMD_SLL, CMD_SRA, CMD_SRL: alu_comb = bus.val1;
            default: alu_comb = '0;
        endcase
    end

    always_comb begin
        taken_comb = 1'b0;
        case (bus.br_type)
            BR_BEZ:  taken_comb = (bus.val1 == '0);
            BR_BNE:  taken_comb = (bus.val1 != bus.src2_val);
            BR_JMP:  taken_comb = 1'b1;
            default: taken_comb = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_next = long_shift ? ST_BUSY : ST_DONE;
            ST_BUSY: if (shift_last)   state_next = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    // Release and accept on the same edge when a new instruction waits.
                    if (bus.in_valid) state_next = long_shift ? ST_BUSY : ST_DONE;
                    else              state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        shift_step    = 1'b0;
        case (state)
            ST_IDLE: bus.in_ready = 1'b1;
            ST_BUSY: shift_step   = 1'b1;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Result / branch registers: branch info captured at accept, the result
    // either at accept or on the final shift step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            addr_q   <= '0;
            taken_q  <= 1'b0;
        end else if (accept) begin
            taken_q <= taken_comb;
            addr_q  <= bus.pc + bus.br_offset;
            if (!long_shift) result_q <= alu_comb;
        end else if (shift_step && shift_last) begin
            result_q <= shift_val;
        end
    end

    assign bus.alu_result = result_q;
    assign bus.br_addr    = addr_q;
    assign bus.br_taken   = taken_q;

    exe_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && long_shift),
        .step      (shift_step),
        .dir       (shift_dir(bus.EXE_CMD)),
        .load_val  (bus.val1),
        .load_cnt  (shamt),
        .shift_val (shift_val),
        .last      (shift_last)
    );

endmodule

// File: tb/tb_exe_unit.sv
// tb_exe_unit: scoreboard bench for exe_unit. The driver pushes the reference
// model's expected result (value, branch info, latency) at each accepted
// instruction; an independent monitor pops and compares whenever a fresh
// result is presented, and checks held results stay stable.
module tb_exe_unit;
    import mips_defs::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exe_unit_if #(.WIDTH(WIDTH)) bus ();

    exe_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] result;
        logic        taken;
        logic [31:0] addr;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    bit rand_ready  = 1'b0;
    bit fixed_ready = 1'b1;
    bit rnd_bit     = 1'b1;
    assign bus.out_ready = rand_ready ? rnd_bit : fixed_ready;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input logic [3:0] cmd, input logic [1:0] br,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] s2, input logic [31:0] p,
                                   input logic [31:0] off);
        exp_t e;
        int   k;
        k = int'(b % 32);
        case (cmd)
            4'b0000: e.result = a + b;
            4'b0010: e.result = a - b;
            4'b0100: e.result = a & b;
            4'b0101: e.result = a | b;
            4'b0110: e.result = ~(a | b);
            4'b0111: e.result = a ^ b;
            4'b1000: e.result = a << k;
            4'b1001: e.result = $signed(a) >>> k;
            4'b1010: e.result = a >> k;
            default: e.result = 32'h0;
        endcase
        e.taken   = (br == 2'b11) || (br == 2'b01 && a == 32'h0) || (br == 2'b10 && a != s2);
        e.addr    = p + off;
        e.lat     = ((cmd inside {4'b1000, 4'b1001, 4'b1010}) && k != 0) ? k + 1 : 1;
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; returns at accept edge + 1.
    task automatic drive_item(input logic [3:0] cmd, input logic [1:0] br,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] s2, input logic [31:0] p,
                              input logic [31:0] off);
        exp_t e;
        bit   rdy;
        bit   done;
        int   c;
        e = model(cmd, br, a, b, s2, p, off);
        bus.EXE_CMD   = cmd;
        bus.br_type   = br;
        bus.val1      = a;
        bus.val2      = b;
        bus.src2_val  = s2;
        bus.pc        = p;
        bus.br_offset = off;
        bus.in_valid  = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            c   = cyc;
            @(posedge clk);
            if (rdy) begin
                e.acc_cyc = c;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        // Scramble operands: only the accepted values may matter.
        bus.EXE_CMD  = 4'($urandom);
        bus.br_type  = 2'($urandom);
        bus.val1     = $urandom;
        bus.val2     = $urandom;
        bus.src2_val = $urandom;
        bus.pc       = $urandom;
        bus.br_offset = $urandom;
        if (!done) check("accept_timeout", 32'(done), 32'h1);
    endtask

    // Monitor / scoreboard checker.
    logic        prev_valid = 1'b0;
    logic        prev_xfer  = 1'b0;
    logic [31:0] prev_res   = '0;
    logic [31:0] prev_addr  = '0;
    logic        prev_taken = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (bus.out_valid && (!prev_valid || prev_xfer)) begin
                if (sb.size() == 0) begin
                    check("stray_result_valid", 32'(bus.out_valid), 32'h0);
                end else begin
                    mon_e = sb[0];
                    check("alu_result", bus.alu_result, mon_e.result);
                    check("br_taken", 32'(bus.br_taken), 32'(mon_e.taken));
                    check("br_addr", bus.br_addr, mon_e.addr);
                    check("latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                end
            end else if (bus.out_valid && prev_valid) begin
                check("hold_result", bus.alu_result, prev_res);
                check("hold_br", {bus.br_addr[30:0], bus.br_taken}, {prev_addr[30:0], prev_taken});
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
            prev_valid = bus.out_valid;
            prev_xfer  = bus.out_valid && bus.out_ready;
            prev_res   = bus.alu_result;
            prev_addr  = bus.br_addr;
            prev_taken = bus.br_taken;
        end
    end

    logic [3:0] cmds [11] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                              4'b1000, 4'b1001, 4'b1010, 4'b0001, 4'b1111};

    initial begin
        bus.in_valid  = 1'b0;
        bus.EXE_CMD   = '0;
        bus.br_type   = '0;
        bus.val1      = '0;
        bus.val2      = '0;
        bus.src2_val  = '0;
        bus.pc        = '0;
        bus.br_offset = '0;

        // Reset state.
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_alu_result", bus.alu_result, 32'h0);
        check("rst_br_addr", bus.br_addr, 32'h0);
        check("rst_br_taken", 32'(bus.br_taken), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_after_reset", 32'(bus.in_ready), 32'h1);
        align();

        // ADD 7+5, then drop to IDLE.
        drive_item(4'b0000, 2'b00, 32'd7, 32'd5, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("add_valid_next", 32'(bus.out_valid), 32'h1);
        check("add_result", bus.alu_result, 32'd12);
        @(negedge clk);
        check("idle_valid_low", 32'(bus.out_valid), 32'h0);
        align();

        // SRA 0x80000000 by 4: four busy cycles.
        drive_item(4'b1001, 2'b00, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sra_busy_in_ready", 32'(bus.in_ready), 32'h0);
        end
        @(negedge clk);
        check("sra_valid", 32'(bus.out_valid), 32'h1);
        check("sra_result", bus.alu_result, 32'hF800_0000);
        align();

        // Branches.
        drive_item(4'b0000, 2'b10, 32'd3, 32'd0, 32'd4, 32'h100, 32'h20);
        @(negedge clk);
        check("bne_taken", 32'(bus.br_taken), 32'h1);
        check("bne_addr", bus.br_addr, 32'h120);
        align();
        drive_item(4'b0000, 2'b01, 32'd1, 32'd0, 32'd0, 32'h200, 32'h4);
        @(negedge clk);
        check("bez_not_taken", 32'(bus.br_taken), 32'h0);
        align();

        // Backpressure on SUB 2-5, then a queued XOR accepted at release.
        fixed_ready = 1'b0;
        drive_item(4'b0010, 2'b00, 32'd2, 32'd5, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_result", bus.alu_result, 32'hFFFF_FFFD);
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        end
        align();
        fixed_ready = 1'b1;
        drive_item(4'b0111, 2'b00, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0, 32'd0);
        repeat (2) align();

        // Shift by zero (val2=32 -> amount 0) and an undefined command.
        drive_item(4'b1000, 2'b00, 32'hDEAD_BEEF, 32'd32, 32'd0, 32'd0, 32'd0);
        drive_item(4'b1111, 2'b11, 32'h1234, 32'h5678, 32'd0, 32'h10, 32'h8);
        repeat (2) align();

        // Reset in the middle of SLL 1 by 20.
        drive_item(4'b1000, 2'b11, 32'd1, 32'd20, 32'd0, 32'h40, 32'h4);
        repeat (2) align();
        rst = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_alu_result", bus.alu_result, 32'h0);
        check("midrst_br_addr", bus.br_addr, 32'h0);
        check("midrst_br_taken", 32'(bus.br_taken), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_release_ready", 32'(bus.in_ready), 32'h1);
        align();
        drive_item(4'b0000, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0);
        repeat (25) align();

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  cmd;
            logic [31:0] a, b, s2;
            repeat ($urandom_range(0, 2)) align();
            cmd = cmds[$urandom_range(0, 10)];
            a   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            b   = $urandom;
            if (cmd inside {4'b1000, 4'b1001, 4'b1010}) b[4:0] = 5'($urandom_range(0, 12));
            s2  = ($urandom_range(0, 1) == 0) ? a : $urandom;
            drive_item(cmd, 2'($urandom), a, b, s2, $urandom, $urandom);
        end
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;
        for (int t = 0; t < 100 && sb.size() != 0; t++) align();
        check("drain_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
